// File: rtl/demux_dispatch_pkg.sv
// Shared types and helpers for the 1-to-4 demux dispatch controller.
package demux_dispatch_pkg;

   localparam int unsigned NUM_CH = 4;
   localparam int unsigned SEL_W  = 2;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      ROUTE = 1'b1
   } state_t;

   typedef struct packed {
      logic             found;
      logic [SEL_W-1:0] idx;
   } pick_t;

   // First set bit of mask, searching ptr, ptr+1, ... with wrap-around.
   function automatic pick_t rr_search(input logic [NUM_CH-1:0] mask,
                                       input logic [SEL_W-1:0]  ptr);
      pick_t            r;
      logic [SEL_W-1:0] j;
      r = '0;
      // Walk farthest-first so the nearest enabled channel wins last.
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         j = ptr + SEL_W'(k);
         if (mask[j]) begin
            r.found = 1'b1;
            r.idx   = j;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/demux_1x4.sv
// Existing 1-to-4 demultiplexer: routes din onto the output selected by s.
module demux_1x4 (
   input  logic       din,
   input  logic [1:0] s,
   output logic [3:0] y
);

   // Single active bit at position s when din is high.
   always_comb begin
      y    = '0;
      y[s] = din;
   end

endmodule

// File: rtl/demux_dispatch_ctrl_rr_pick4.sv
// Combinational rotating-priority picker over a 4-bit enable mask.
module rr_pick4
   import demux_dispatch_pkg::*;
(
   input  logic [NUM_CH-1:0] mask,
   input  logic [SEL_W-1:0]  ptr,
   output logic [SEL_W-1:0]  idx,
   output logic              found
);

   pick_t pick;

   // Resolve the first enabled channel at or after ptr.
   always_comb begin
      pick  = rr_search(mask, ptr);
      idx   = pick.idx;
      found = pick.found;
   end

endmodule

// File: rtl/demux_dispatch_ctrl.sv
// Dispatch controller: accepts one word, commits a destination, holds it
// until the selected consumer takes it.
module demux_dispatch_ctrl
   import demux_dispatch_pkg::*;
#(
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_directed,
   input  logic [SEL_W-1:0]  in_dest,
   input  logic [NUM_CH-1:0] ch_en,
   output logic [NUM_CH-1:0] out_valid,
   input  logic [NUM_CH-1:0] out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [SEL_W-1:0]  sel,
   output logic              busy,
   output logic              err_drop
);

   state_t            state, state_n;
   logic [DATA_W-1:0] hold_data, hold_data_n;
   logic [SEL_W-1:0]  sel_n;
   logic [SEL_W-1:0]  rr_ptr, rr_ptr_n;
   logic              err_drop_n;
   logic              in_ready_n;
   logic [SEL_W-1:0]  pick_idx;
   logic              pick_found;
   logic [SEL_W-1:0]  dest;
   logic              dest_ok;
   logic              routing;

   rr_pick4 u_pick (
      .mask  (ch_en),
      .ptr   (rr_ptr),
      .idx   (pick_idx),
      .found (pick_found)
   );

   assign routing = (state == ROUTE);

   demux_1x4 u_demux (
      .din (routing),
      .s   (sel),
      .y   (out_valid)
   );

   assign out_data = hold_data;
   assign busy     = routing;

   // State and datapath registers; reset discards any held word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         hold_data <= '0;
         sel       <= '0;
         rr_ptr    <= '0;
         err_drop  <= 1'b0;
         in_ready  <= 1'b0;
      end else begin
         state     <= state_n;
         hold_data <= hold_data_n;
         sel       <= sel_n;
         rr_ptr    <= rr_ptr_n;
         err_drop  <= err_drop_n;
         in_ready  <= in_ready_n;
      end
   end

   // Destination resolution: directed request or round-robin pick.
   always_comb begin
      dest    = pick_idx;
      dest_ok = pick_found;
      if (in_directed) begin
         dest    = in_dest;
         dest_ok = ch_en[in_dest];
      end
   end

   // Next-state and register updates.
   always_comb begin
      state_n     = state;
      hold_data_n = hold_data;
      sel_n       = sel;
      rr_ptr_n    = rr_ptr;
      err_drop_n  = 1'b0;
      unique case (state)
         IDLE: begin
            if (in_valid && in_ready) begin
               hold_data_n = in_data;
               if (dest_ok) begin
                  sel_n   = dest;
                  state_n = ROUTE;
               end else begin
                  err_drop_n = 1'b1;
               end
            end
         end
         ROUTE: begin
            if (out_ready[sel]) begin
               rr_ptr_n = SEL_W'(sel + SEL_W'(1));
               state_n  = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
      in_ready_n = (state_n == IDLE);
   end

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Directed-vector bench for demux_dispatch_ctrl.
module tb_demux_dispatch_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       in_directed;
   logic [1:0] in_dest;
   logic [3:0] ch_en;
   logic [3:0] out_valid;
   logic [3:0] out_ready;
   logic [7:0] out_data;
   logic [1:0] sel;
   logic       busy;
   logic       err_drop;

   int vec_cnt = 0;
   int err_cnt = 0;

   demux_dispatch_ctrl #(.DATA_W(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_directed (in_directed),
      .in_dest     (in_dest),
      .ch_en       (ch_en),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .sel         (sel),
      .busy        (busy),
      .err_drop    (err_drop)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance to 1 ns after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one word for a single edge.
   task automatic send(input logic [7:0] d, input logic dir, input logic [1:0] dst);
      in_valid    = 1'b1;
      in_data     = d;
      in_directed = dir;
      in_dest     = dst;
      step();
      in_valid    = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_directed = 1'b0;
      in_dest = '0; ch_en = 4'b1111; out_ready = 4'b0000;
      step(); step();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_data", out_data, 0);
      rst = 1'b0;
      step();
      chk("post_rst_in_ready", in_ready, 1);

      // Reset while holding 0xA5.
      send(8'hA5, 1'b0, 2'd0);
      chk("a5_out_valid", out_valid, 4'b0001);
      chk("a5_busy", busy, 1);
      rst = 1'b1;
      #1;
      chk("async_rst_out_valid", out_valid, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_out_data", out_data, 0);
      chk("async_rst_in_ready", in_ready, 0);
      step();
      rst = 1'b0;
      out_ready = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("a5_never_out_valid", out_valid, 0);
      end
      chk("a5_rel_in_ready", in_ready, 1);

      // Round-robin, all channels enabled.
      for (int i = 0; i < 4; i++) begin
         send(8'h10 + 8'(i), 1'b0, 2'd0);
         chk("rr_out_valid", out_valid, 32'(4'b0001 << i));
         chk("rr_out_data", out_data, 32'(8'h10 + 8'(i)));
         chk("rr_sel", sel, i);
         chk("rr_in_ready_low", in_ready, 0);
         step();
         chk("rr_done_valid", out_valid, 0);
         chk("rr_done_in_ready", in_ready, 1);
      end

      // Round-robin skip with ch_en=1010; rr_ptr wrapped to 0.
      ch_en = 4'b1010;
      send(8'h21, 1'b0, 2'd0);
      chk("skip0_out_valid", out_valid, 4'b0010);
      step();
      send(8'h22, 1'b0, 2'd0);
      chk("skip1_out_valid", out_valid, 4'b1000);
      step();
      send(8'h23, 1'b0, 2'd0);
      chk("skip2_out_valid", out_valid, 4'b0010);
      step();
      ch_en = 4'b0000;
      send(8'h24, 1'b0, 2'd0);
      chk("none_err_drop", err_drop, 1);
      chk("none_out_valid", out_valid, 0);
      chk("none_in_ready", in_ready, 1);
      step();
      chk("none_err_clear", err_drop, 0);
      chk("none_out_valid2", out_valid, 0);

      // Back-to-back drops.
      send(8'h25, 1'b0, 2'd0);
      chk("b2b_err0", err_drop, 1);
      send(8'h26, 1'b0, 2'd0);
      chk("b2b_err1", err_drop, 1);
      step();
      chk("b2b_err_clear", err_drop, 0);

      // Directed to disabled channel, then enabled.
      ch_en = 4'b1011;
      send(8'h5A, 1'b1, 2'd2);
      chk("dir_dis_err", err_drop, 1);
      chk("dir_dis_valid", out_valid, 0);
      step();
      chk("dir_dis_err_clear", err_drop, 0);
      chk("dir_dis_valid2", out_valid, 0);
      ch_en = 4'b1111;
      send(8'h5A, 1'b1, 2'd2);
      chk("dir_en_valid", out_valid, 4'b0100);
      chk("dir_en_sel", sel, 2);
      chk("dir_en_data", out_data, 8'h5A);
      step();
      chk("dir_en_done", out_valid, 0);

      // Backpressure on channel 3.
      out_ready = 4'b0111;
      send(8'h77, 1'b1, 2'd3);
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", out_valid, 4'b1000);
         chk("bp_data", out_data, 8'h77);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_busy", busy, 1);
         step();
      end
      out_ready = 4'b1111;
      step();
      chk("bp_done_valid", out_valid, 0);
      chk("bp_done_in_ready", in_ready, 1);
      chk("bp_done_busy", busy, 0);

      // ch_en cleared while routing to channel 1 (rr_ptr is 0).
      ch_en = 4'b0010;
      out_ready = 4'b0000;
      send(8'h31, 1'b0, 2'd0);
      ch_en = 4'b0000;
      chk("chg_valid0", out_valid, 4'b0010);
      step();
      chk("chg_valid1", out_valid, 4'b0010);
      chk("chg_data", out_data, 8'h31);
      out_ready = 4'b0010;
      step();
      chk("chg_done_valid", out_valid, 0);
      chk("chg_done_in_ready", in_ready, 1);
      chk("chg_no_err", err_drop, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
